// File: rtl/cache_control_pkg.sv
// Shared types for the LC-3b L1 cache controller: FSM state, control bundle
// and the datapath-side offset/line types.
package cache_control_pkg;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } lc3b_cache_state;

  localparam int PERF_W_DEFAULT = 16;

  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [127:0] lc3b_c_line;

  // Every datapath/pmem control the FSM produces in one cycle.
  typedef struct packed {
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_addr_sel;
    logic data_sel;
    logic load_data;
    logic load_tag;
    logic load_valid;
    logic load_dirty;
    logic dirty_in;
  } cache_ctrl_t;

endpackage

// File: rtl/cache_control_if.sv
// Handshake and control bundle between the cache controller (slave side) and
// the CPU port, cache datapath and physical memory (master side).
interface cache_control_if;

  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic hit;
  logic dirty;
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  logic data_sel;
  logic load_data;
  logic load_tag;
  logic load_valid;
  logic load_dirty;
  logic dirty_in;

  modport master (
    output mem_read, mem_write, hit, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel,
           load_data, load_tag, load_valid, load_dirty, dirty_in
  );

  modport slave (
    input  mem_read, mem_write, hit, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel,
           load_data, load_tag, load_valid, load_dirty, dirty_in
  );

endinterface

// File: rtl/cache_perf_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module cache_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the direct-mapped write-back L1 cache (CHECK/WRITEBACK/ALLOCATE).
// Define CACHE_PERF_CNT_EN to add the hit/miss/writeback performance counters.
module cache_control
  import cache_control_pkg::*;
`ifdef CACHE_PERF_CNT_EN
#(
  parameter int PERF_W = PERF_W_DEFAULT
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  cache_control_if.slave    bus
`ifdef CACHE_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt,
  output logic [PERF_W-1:0] wb_cnt
`endif
);

  lc3b_cache_state state_q;
  lc3b_cache_state state_d;
  cache_ctrl_t     ctrl;
  logic            req;

  assign req = bus.mem_read | bus.mem_write;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      CHECK: begin
        if (req) begin
          if (bus.hit) begin
            ctrl.mem_resp = 1'b1;
            // A simultaneous read+write is illegal; the write path wins.
            if (bus.mem_write) begin
              ctrl.load_data  = 1'b1;
              ctrl.load_dirty = 1'b1;
              ctrl.dirty_in   = 1'b1;
            end
          end else begin
            state_d = bus.dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        ctrl.pmem_write    = 1'b1;
        ctrl.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        ctrl.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          ctrl.load_data  = 1'b1;
          ctrl.data_sel   = 1'b1;
          ctrl.load_tag   = 1'b1;
          ctrl.load_valid = 1'b1;
          ctrl.load_dirty = 1'b1;
          state_d         = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.mem_resp      = ctrl.mem_resp;
  assign bus.pmem_read     = ctrl.pmem_read;
  assign bus.pmem_write    = ctrl.pmem_write;
  assign bus.pmem_addr_sel = ctrl.pmem_addr_sel;
  assign bus.data_sel      = ctrl.data_sel;
  assign bus.load_data     = ctrl.load_data;
  assign bus.load_tag      = ctrl.load_tag;
  assign bus.load_valid    = ctrl.load_valid;
  assign bus.load_dirty    = ctrl.load_dirty;
  assign bus.dirty_in      = ctrl.dirty_in;

`ifdef CACHE_PERF_CNT_EN
  logic miss_start;
  logic wb_done;
  logic miss_pend_q;
  logic miss_pend_d;

  assign miss_start = (state_q == CHECK) && req && !bus.hit;
  assign wb_done    = (state_q == WRITEBACK) && bus.pmem_resp;

  // Marks a request that missed, so its final mem_resp is not counted as a hit.
  always_comb begin
    miss_pend_d = miss_pend_q;
    if (miss_start) begin
      miss_pend_d = 1'b1;
    end else if (ctrl.mem_resp) begin
      miss_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_pend_q <= 1'b0;
    end else begin
      miss_pend_q <= miss_pend_d;
    end
  end

  cache_perf_counter #(.W(PERF_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (perf_clr),
    .inc_i (ctrl.mem_resp && !miss_pend_q),
    .cnt_o (hit_cnt)
  );

  cache_perf_counter #(.W(PERF_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (perf_clr),
    .inc_i (miss_start),
    .cnt_o (miss_cnt)
  );

  cache_perf_counter #(.W(PERF_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (perf_clr),
    .inc_i (wb_done),
    .cnt_o (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized self-checking bench for cache_control; expected per-cycle outputs
// come from a transaction-level timing model and a 4-line cache model.
module tb_cache_control;

  localparam logic [9:0] O_RESP   = 10'b10_0000_0000;
  localparam logic [9:0] O_PRD    = 10'b01_0000_0000;
  localparam logic [9:0] O_PWR    = 10'b00_1000_0000;
  localparam logic [9:0] O_ASEL   = 10'b00_0100_0000;
  localparam logic [9:0] O_DSEL   = 10'b00_0010_0000;
  localparam logic [9:0] O_LDATA  = 10'b00_0001_0000;
  localparam logic [9:0] O_LTAG   = 10'b00_0000_1000;
  localparam logic [9:0] O_LVAL   = 10'b00_0000_0100;
  localparam logic [9:0] O_LDIRTY = 10'b00_0000_0010;
  localparam logic [9:0] O_DIN    = 10'b00_0000_0001;

  localparam logic [9:0] EXP_RD_HIT = O_RESP;
  localparam logic [9:0] EXP_WR_HIT = O_RESP | O_LDATA | O_LDIRTY | O_DIN;
  localparam logic [9:0] EXP_WB     = O_PWR | O_ASEL;
  localparam logic [9:0] EXP_FILL   = O_PRD | O_DSEL | O_LDATA | O_LTAG | O_LVAL | O_LDIRTY;
  localparam int         CNT_MAX    = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;

  cache_control_if bus ();

`ifdef CACHE_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] wb_cnt;
`endif

  cache_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .perf_clr (perf_clr),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Performance-counter reference.
  int hit_m = 0, miss_m = 0, wb_m = 0;
  bit pend_m = 1'b0;

  // Cache contents reference used to generate hit/dirty for random traffic.
  bit       valid_m [4];
  bit [1:0] tag_m   [4];
  bit       dirty_m [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] observe();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.data_sel,
            bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty, bus.dirty_in};
  endfunction

  // One clock cycle: drive at negedge, compare combinational outputs 1ns later,
  // then advance the counter model for the upcoming rising edge.
  task automatic cycle(input string tag, input logic rd, input logic wr, input logic h,
                       input logic d, input logic resp, input logic [9:0] exp,
                       input bit miss_ev, input bit wb_ev);
    bit hit_ev;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit       = h;
    bus.dirty     = d;
    bus.pmem_resp = resp;
`ifdef CACHE_PERF_CNT_EN
    perf_clr = clr_req;
`endif
    #1;
    check(tag, 32'(observe()), 32'(exp));
`ifdef CACHE_PERF_CNT_EN
    check({tag, ".hit_cnt"},  32'(hit_cnt),  hit_m);
    check({tag, ".miss_cnt"}, 32'(miss_cnt), miss_m);
    check({tag, ".wb_cnt"},   32'(wb_cnt),   wb_m);
`endif
    hit_ev = 1'b0;
    if ((exp & O_RESP) != 0) begin
      if (pend_m) pend_m = 1'b0;
      else        hit_ev = 1'b1;
    end
    if (miss_ev) pend_m = 1'b1;
    if (clr_req) begin
      hit_m = 0; miss_m = 0; wb_m = 0;
    end else begin
      if (hit_ev  && hit_m  < CNT_MAX) hit_m++;
      if (miss_ev && miss_m < CNT_MAX) miss_m++;
      if (wb_ev   && wb_m   < CNT_MAX) wb_m++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty     = 1'b0;
    bus.pmem_resp = 1'b0;
    hit_m = 0; miss_m = 0; wb_m = 0; pend_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A full CPU request from first sighting to completion. m/n are the pmem
  // latencies; drop_at>0 releases the request from that ALLOCATE cycle on.
  task automatic txn_run(input logic w, input logic rd_too, input logic h, input logic d,
                         input int m, input int n, input int drop_at);
    logic rd;
    bit   live;
    rd = !w || rd_too;
    if (h) begin
      cycle("hit", rd, w, 1'b1, d, 1'b0, w ? EXP_WR_HIT : EXP_RD_HIT, 1'b0, 1'b0);
      return;
    end
    cycle("miss_check", rd, w, 1'b0, d, 1'b0, 10'b0, 1'b1, 1'b0);
    if (d) begin
      for (int i = 1; i <= m; i++)
        cycle("writeback", rd, w, 1'b0, d, i == m, EXP_WB, 1'b0, i == m);
    end
    live = 1'b1;
    for (int i = 1; i <= n; i++) begin
      if (drop_at > 0 && i >= drop_at) live = 1'b0;
      cycle("allocate", rd & live, w & live, 1'b0, d, i == n,
            (i == n) ? EXP_FILL : O_PRD, 1'b0, 1'b0);
    end
    if (live)
      cycle("fill_hit", rd, w, 1'b1, 1'b0, 1'b0, w ? EXP_WR_HIT : EXP_RD_HIT, 1'b0, 1'b0);
    else
      cycle("dropped_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty     = 1'b0;
    bus.pmem_resp = 1'b0;
    foreach (valid_m[i]) begin
      valid_m[i] = 1'b0; tag_m[i] = 2'd0; dirty_m[i] = 1'b0;
    end

    do_reset();
    cycle("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
    cycle("idle_hit_dirty", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'b0, 1'b0, 1'b0);

    txn_run(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);   // read hit
    txn_run(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);   // write hit
    txn_run(1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 0);   // clean read miss, 7 cycles
    txn_run(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0);   // read+write together: write path

    do_reset();
    txn_run(1'b1, 1'b0, 1'b0, 1'b1, 3, 4, 0);   // dirty write miss
    cycle("after_dirty_miss", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);

    // Reset while ALLOCATE waits on memory: pmem_read must drop, no loads.
    cycle("rst_miss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b1, 1'b0);
    cycle("rst_alloc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_PRD, 1'b0, 1'b0);
    cycle("rst_alloc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_PRD, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    hit_m = 0; miss_m = 0; wb_m = 0; pend_m = 1'b0;
    cycle("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
    cycle("post_rst_hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EXP_RD_HIT, 1'b0, 1'b0);

    // Dropped request: memory transfer completes, then controller idles.
    txn_run(1'b0, 1'b0, 1'b0, 1'b1, 2, 3, 2);
    txn_run(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);

    // Random traffic over a 4-line, 4-tag cache model.
    for (int t = 0; t < 200; t++) begin
      int  idx, tg, m, n, drop;
      bit  w, both, h, d;
      idx  = $urandom_range(0, 3);
      tg   = $urandom_range(0, 3);
      w    = $urandom_range(0, 1);
      both = w && ($urandom_range(0, 7) == 0);
      h    = valid_m[idx] && (tag_m[idx] == 2'(tg));
      d    = dirty_m[idx];
      m    = $urandom_range(1, 5);
      n    = $urandom_range(1, 5);
      drop = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n) : 0;
      txn_run(w, both, h, d, m, n, drop);
      if (!h) begin
        valid_m[idx] = 1'b1;
        tag_m[idx]   = 2'(tg);
        dirty_m[idx] = 1'b0;
      end
      if (w && (h || drop == 0)) dirty_m[idx] = 1'b1;
      if ($urandom_range(0, 1) == 1)
        cycle("idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0, 10'b0, 1'b0, 1'b0);
    end

`ifdef CACHE_PERF_CNT_EN
    // Saturation: clear, then 0xFFFF+1 hits, then clear alongside a hit.
    clr_req = 1'b1;
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
    clr_req = 1'b0;
    for (int i = 0; i < CNT_MAX + 1; i++)
      cycle("sat_hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EXP_RD_HIT, 1'b0, 1'b0);
    cycle("sat_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
    check("hit_saturated", 32'(hit_cnt), CNT_MAX);
    clr_req = 1'b1;
    cycle("clr_with_hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EXP_RD_HIT, 1'b0, 1'b0);
    clr_req = 1'b0;
    cycle("after_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
    check("hit_cleared", 32'(hit_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
